fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the P7 five-stage MIPS pipeline; sits directly upstream of the IF/ID pipeline register and produces its F_PC, F_I, F_Exc and F_BD inputs.
- Owns the architectural PC register and selects next PC from sequential, branch/jump, eret (EPC) and interrupt/exception redirect.
- Drives the instruction-memory address, detects fetch address errors, and squashes the fetched word where required.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry address.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- WE  in  1  pipeline advance enable; 0 = stall, hold PC.
- IntReq  in  1  interrupt/exception taken this cycle (from CP0).
- D_Branch  in  4  branch-class code of the instruction in D (shared codes; 0 = none).
- D_jump  in  1  D-stage branch/jump resolved taken.
- D_target  in  32  D-stage branch/jump target.
- EPC  in  32  CP0 EPC, used when D_Branch == ERET.
- im_addr  out  32  instruction-memory word address (= F_PC).
- im_rdata  in  32  instruction-memory read data, combinational on im_addr.
- F_PC  out  32  PC of the instruction in F.
- F_I  out  32  instruction word sent to IF/ID (0 when squashed).
- F_Exc  out  [6:2]  fetch exception code (0 none, 4 AdEL).
- F_BD  out  1  instruction in F is in a branch delay slot.

Behaviour:
- State: 32-bit PC register; optional counters only. No FSM beyond the PC register.
- Reset: PC <= RESET_PC; with reset asserted F_PC = 32'h3000, F_BD = 0, F_Exc = 0, F_I = im_rdata.
- Next-PC priority, evaluated each posedge: reset > IntReq > !WE > ERET > D_jump > PC+4.
- IntReq: PC <= HANDLER_PC regardless of WE. Same cycle IF/ID clears itself.
- !WE: PC holds; F outputs stay stable for the whole stall.
- D_Branch == ERET and WE: PC <= EPC, no delay slot. F_I forced to 0 and F_Exc forced to 0 that cycle, so the word fetched after eret enters D as a nop.
- D_jump and WE (non-eret branch class): PC <= D_target. The instruction currently in F is the delay slot and executes.
- Otherwise with WE: PC <= PC+4, 32-bit wrap, no overflow detection.
- F_BD = (D_Branch != 0) && (D_Branch != ERET), combinational. It is set whether or not the branch is taken.
- AdEL: F_PC[1:0] != 0, or F_PC < IM_LO, or F_PC > IM_HI, gives F_Exc = 4 and F_I = 0. F_PC still reports the bad PC so CP0 sets EPC/BadVAddr.
- Simultaneous AdEL and eret squash: the eret squash wins, F_Exc = 0.
- Simultaneous IntReq and stall: IntReq wins, PC redirects.
- Reset mid-stall or mid-branch: reset wins and no pending redirect survives.
- Latency: im_addr to F_I is combinational, zero cycles. Redirect becomes visible on F_PC one cycle after the decision.

Optional Feature:
- FETCH_PERF_EN defined: adds outputs fetch_cnt[31:0] and stall_cnt[31:0], both cleared by reset.
  - fetch_cnt increments on each posedge with WE=1 and IntReq=0.
  - stall_cnt increments on each posedge with WE=0.
  - Both wrap at 2^32.
- FETCH_PERF_EN undefined: the ports and counters are absent and the block has identical PC behaviour.

Decomposition:
- Shared define file (existing define.v) holds the D_Branch codes (BEQ..REG, ERET), the exception code AdEL = 4, and the RESET_PC/HANDLER_PC constants.
- One natural sub-module, fetch_addr_check: combinational AdEL detection from PC and the IM_LO/IM_HI bounds.

Test Plan:
- Reset held 2 cycles then released, WE=1, no branches -> F_PC sequence 3000, 3004, 3008; F_Exc = 0; F_BD = 0.
- D_Branch=BEQ, D_jump=1, D_target=32'h3100 at F_PC=3008 -> F_BD=1 that cycle; next F_PC=3100.
- WE=0 for 3 cycles at F_PC=300C, D_jump=1 -> F_PC stays 300C for 3 cycles, then redirects to the target on the first WE=1 edge.
- D_Branch=ERET, EPC=32'h3040 at F_PC=3020 -> F_I=0 and F_Exc=0 that cycle; next F_PC=3040; F_BD=0.
- D_jump=1, D_target=32'h3002 -> next cycle F_PC=3002, F_Exc=4, F_I=0. A second case with D_target=32'h7000 gives F_Exc=4.
- IntReq=1 together with WE=0 at F_PC=3050 -> next F_PC=4180. With FETCH_PERF_EN, stall_cnt increments by 1 and fetch_cnt is unchanged.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the P7 IF stage: branch-class codes, exception
// codes and the default reset/handler addresses.
package fetch_stage_pkg;

    // Branch-class codes carried by D_Branch; 0 means no branch in D
    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BLEZ = 4'd3,
        BR_BGTZ = 4'd4,
        BR_BLTZ = 4'd5,
        BR_BGEZ = 4'd6,
        BR_J    = 4'd7,
        BR_JAL  = 4'd8,
        BR_REG  = 4'd9,
        BR_ERET = 4'd10
    } branch_e;

    localparam logic [6:2] EXC_NONE = 5'd0;
    localparam logic [6:2] EXC_ADEL = 5'd4;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] DEF_IM_LO      = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_HI      = 32'h0000_6FFC;

    // A branch-class instruction in D owns a delay slot, except eret
    function automatic logic has_delay_slot(input logic [3:0] code);
        return (code != BR_NONE) && (code != BR_ERET);
    endfunction

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational fetch address-error (AdEL) detection: misaligned word
// address or outside the instruction-memory window [im_lo, im_hi].
module fetch_addr_check #(
    parameter logic [31:0] IM_LO = 32'h0000_3000,
    parameter logic [31:0] IM_HI = 32'h0000_6FFC
) (
    input  logic [31:0] pc,
    output logic        adel
);

    // Flag any fetch the instruction memory cannot legally serve
    always_comb begin
        adel = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the P7 five-stage MIPS pipeline. Owns the PC, picks the next
// PC (reset > interrupt > stall > eret > taken branch/jump > PC+4), flags
// fetch address errors and squashes the word fetched under an eret.
// Optional build macro FETCH_PERF_EN adds fetch_cnt/stall_cnt counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC,
    parameter logic [31:0] IM_LO      = DEF_IM_LO,
    parameter logic [31:0] IM_HI      = DEF_IM_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic        IntReq,
    input  logic [3:0]  D_Branch,
    input  logic        D_jump,
    input  logic [31:0] D_target,
    input  logic [31:0] EPC,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] F_PC,
    output logic [31:0] F_I,
    output logic [6:2]  F_Exc,
    output logic        F_BD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    logic [31:0] pc;
    logic        is_eret;
    logic        eret_squash;
    logic        adel;

    // Next-PC selection; a stall only holds when no interrupt is being taken
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (IntReq) begin
            pc <= HANDLER_PC;
        end else if (!WE) begin
            pc <= pc;
        end else if (is_eret) begin
            pc <= EPC;
        end else if (D_jump) begin
            pc <= D_target;
        end else begin
            pc <= pc + 32'd4;
        end
    end

    // Reset forces the reset PC onto the fetch port before the first edge
    always_comb begin
        F_PC        = reset ? RESET_PC : pc;
        im_addr     = F_PC;
        is_eret     = (D_Branch == BR_ERET);
        eret_squash = !reset && WE && is_eret;
    end

    fetch_addr_check #(
        .IM_LO(IM_LO),
        .IM_HI(IM_HI)
    ) u_addr_check (
        .pc  (F_PC),
        .adel(adel)
    );

    // Eret squash beats AdEL so the post-eret word enters D as a clean nop
    always_comb begin
        F_BD  = !reset && has_delay_slot(D_Branch);
        F_Exc = EXC_NONE;
        F_I   = im_rdata;
        if (eret_squash) begin
            F_I = 32'd0;
        end else if (adel) begin
            F_I   = 32'd0;
            F_Exc = EXC_ADEL;
        end
    end

`ifdef FETCH_PERF_EN
    // Performance counters: advancing fetches and stalled cycles, both wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (WE && !IntReq) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (!WE) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard testbench for fetch_stage: directed per-cycle vectors push
// expected outputs; a negedge monitor pops and compares them.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic        WE;
    logic        IntReq;
    logic [3:0]  D_Branch;
    logic        D_jump;
    logic [31:0] D_target;
    logic [31:0] EPC;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] F_PC;
    logic [31:0] F_I;
    logic [6:2]  F_Exc;
    logic        F_BD;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        bd;
        logic [31:0] fcnt;
        logic [31:0] scnt;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    logic [31:0] modelFetch = 0;
    logic [31:0] modelStall = 0;

    fetch_stage dut (
        .clk     (clk),
        .reset   (reset),
        .WE      (WE),
        .IntReq  (IntReq),
        .D_Branch(D_Branch),
        .D_jump  (D_jump),
        .D_target(D_target),
        .EPC     (EPC),
        .im_addr (im_addr),
        .im_rdata(im_rdata),
        .F_PC    (F_PC),
        .F_I     (F_I),
        .F_Exc   (F_Exc),
        .F_BD    (F_BD)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt(fetch_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    assign im_rdata = memWord(im_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; expectations describe the outputs seen this cycle
    task automatic applyStimulus(input logic rst, input logic we, input logic irq,
                                 input logic [3:0] br, input logic jmp,
                                 input logic [31:0] tgt, input logic [31:0] epc,
                                 input logic [31:0] expPc, input logic expBd,
                                 input logic [4:0] expExc, input logic expZero);
        exp_t e;
        @(posedge clk);
        #1;
        reset    = rst;
        WE       = we;
        IntReq   = irq;
        D_Branch = br;
        D_jump   = jmp;
        D_target = tgt;
        EPC      = epc;
        e.pc    = expPc;
        e.instr = expZero ? 32'd0 : memWord(expPc);
        e.exc   = expExc;
        e.bd    = expBd;
        e.fcnt  = modelFetch;
        e.scnt  = modelStall;
        sbq.push_back(e);
        if (rst) begin
            modelFetch = 0;
            modelStall = 0;
        end else begin
            if (we && !irq) modelFetch = modelFetch + 1;
            if (!we) modelStall = modelStall + 1;
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            checkOutput("F_PC", F_PC, e.pc);
            checkOutput("im_addr", im_addr, e.pc);
            checkOutput("F_I", F_I, e.instr);
            checkOutput("F_Exc", {27'd0, F_Exc}, {27'd0, e.exc});
            checkOutput("F_BD", {31'd0, F_BD}, {31'd0, e.bd});
`ifdef FETCH_PERF_EN
            checkOutput("fetch_cnt", fetch_cnt, e.fcnt);
            checkOutput("stall_cnt", stall_cnt, e.scnt);
`endif
        end
    end

    initial begin
        reset = 1'b1; WE = 1'b1; IntReq = 1'b0; D_Branch = BR_NONE;
        D_jump = 1'b0; D_target = 32'd0; EPC = 32'd0;
        //            rst we  irq br       jmp tgt            epc            expPc          bd exc  zero
        applyStimulus(1, 1, 0, BR_NONE, 0, 32'h0,        32'h0,        32'h0000_3000, 0, 5'd0, 0);
        applyStimulus(1, 1, 0, BR_NONE, 0, 32'h0,        32'h0,        32'h0000_3000, 0, 5'd0, 0);
        applyStimulus(0, 1, 0, BR_NONE, 0, 32'h0,        32'h0,        32'h0000_3000, 0, 5'd0, 0);
        applyStimulus(0, 1, 0, BR_NONE, 0, 32'h0,        32'h0,        32'h0000_3004, 0, 5'd0, 0);
        applyStimulus(0, 1, 0, BR_BEQ,  1, 32'h0000_3100, 32'h0,       32'h0000_3008, 1, 5'd0, 0);
        applyStimulus(0, 1, 0, BR_NONE, 0, 32'h0,        32'h0,        32'h0000_3100, 0, 5'd0, 0);
        applyStimulus(0, 0, 0, BR_BNE,  1, 32'h0000_3200, 32'h0,       32'h0000_3104, 1, 5'd0, 0);
        applyStimulus(0, 0, 0, BR_BNE,  1, 32'h0000_3200, 32'h0,       32'h0000_3104, 1, 5'd0, 0);
        applyStimulus(0, 0, 0, BR_BNE,  1, 32'h0000_3200, 32'h0,       32'h0000_3104, 1, 5'd0, 0);
        applyStimulus(0, 1, 0, BR_BNE,  1, 32'h0000_3200, 32'h0,       32'h0000_3104, 1, 5'd0, 0);
        applyStimulus(0, 1, 0, BR_ERET, 0, 32'h0,        32'h0000_3040, 32'h0000_3200, 0, 5'd0, 1);
        applyStimulus(0, 1, 0, BR_BEQ,  1, 32'h0000_3002, 32'h0,       32'h0000_3040, 1, 5'd0, 0);
        applyStimulus(0, 1, 0, BR_NONE, 0, 32'h0,        32'h0,        32'h0000_3002, 0, 5'd4, 1);
        applyStimulus(0, 1, 0, BR_ERET, 0, 32'h0,        32'h0000_3050, 32'h0000_3006, 0, 5'd0, 1);
        applyStimulus(0, 0, 1, BR_NONE, 0, 32'h0,        32'h0,        32'h0000_3050, 0, 5'd0, 0);
        applyStimulus(0, 1, 0, BR_J,    1, 32'h0000_7000, 32'h0,       32'h0000_4180, 1, 5'd0, 0);
        applyStimulus(0, 1, 0, BR_BEQ,  1, 32'h0000_2FFC, 32'h0,       32'h0000_7000, 1, 5'd4, 1);
        applyStimulus(0, 1, 0, BR_BNE,  1, 32'h0000_6FFC, 32'h0,       32'h0000_2FFC, 1, 5'd4, 1);
        applyStimulus(0, 1, 0, BR_NONE, 0, 32'h0,        32'h0,        32'h0000_6FFC, 0, 5'd0, 0);
        applyStimulus(1, 1, 0, BR_BEQ,  1, 32'h0000_3300, 32'h0,       32'h0000_3000, 0, 5'd0, 0);
        applyStimulus(0, 1, 0, BR_NONE, 0, 32'h0,        32'h0,        32'h0000_3000, 0, 5'd0, 0);
        applyStimulus(0, 1, 0, BR_NONE, 0, 32'h0,        32'h0,        32'h0000_3004, 0, 5'd0, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard_drain", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
